// File: rtl/pingpong_ram_ctrl.sv
// pingpong_ram_ctrl
//   Ping-pong frame buffer controller in front of one dual-port RAM. The RAM
//   is split into two banks by the address MSB. Port A writes incoming frames
//   of FRAME_LEN words; port B replays each completed bank, in order, through
//   a 2-entry output FIFO onto a valid/ready stream.
//
// Ports
//   clk, rst_n                 single clock, async active-low reset
//   s_valid/s_ready/s_data     input word stream
//   m_valid/m_ready/m_data     output word stream, m_last on last word of a frame
//   ram_wren_a/addr_a/din_a    RAM port A (write only)
//   ram_rden_b/addr_b/dout_b   RAM port B (read only, 1-cycle read latency)
//   bank_full                  per-bank "frame written, not yet fully read"
//   frame_done                 pulse when the last word of a frame leaves on m_*
//
// Read FSM
//   state   | meaning
//   RD_IDLE | waiting for bank rd_bank to become full
//   RD_READ | issuing reads of bank rd_bank, limited by FIFO credit

module pingpong_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  ram_wren_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic                  ram_rden_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b,
    output logic [1:0]            bank_full,
    output logic                  frame_done
);

    localparam int PW = ADDR_WIDTH - 1;
    localparam logic [PW-1:0] PTR_MAX = '1;

    typedef enum logic {RD_IDLE, RD_READ} rd_state_e;

    rd_state_e             state_q, state_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  drain_bank_q, drain_bank_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [DATA_WIDTH-1:0] fifo_data_d [2];
    logic [1:0]            fifo_last_q, fifo_last_d;
    logic                  fifo_wr_idx_q, fifo_wr_idx_d;
    logic                  fifo_rd_idx_q, fifo_rd_idx_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;

    logic       accept;
    logic       pop;
    logic       push;
    logic       credit;
    logic [2:0] occupancy;

    assign s_ready    = rst_n & ~bank_full_q[wr_bank_q];
    assign accept     = s_valid & s_ready;
    assign m_valid    = (fifo_cnt_q != 2'd0);
    assign m_data     = fifo_data_q[fifo_rd_idx_q];
    assign m_last     = m_valid & fifo_last_q[fifo_rd_idx_q];
    assign pop        = m_valid & m_ready;
    assign push       = inflight_q;
    assign frame_done = pop & fifo_last_q[fifo_rd_idx_q];
    assign bank_full  = bank_full_q;

    assign ram_wren_a = accept;
    assign ram_addr_a = {wr_bank_q, wr_ptr_q};
    assign ram_din_a  = s_data;
    assign ram_addr_b = {rd_bank_q, rd_ptr_q};

    // Words already owned by the FIFO: stored plus the read in flight. A pop
    // this cycle frees a slot early enough for a read issued now, which is
    // what keeps the stream at one word per clock.
    assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    assign credit    = pop ? (occupancy < 3'd3) : (occupancy < 3'd2);

    always_comb begin
        wr_bank_d    = wr_bank_q;
        wr_ptr_d     = wr_ptr_q;
        bank_full_d  = bank_full_q;
        drain_bank_d = drain_bank_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == PTR_MAX) begin
                wr_bank_d = ~wr_bank_q;
            end
        end

        // Reads run ahead of the drain, so the bank that clears is tracked
        // separately from the bank being read.
        if (frame_done) begin
            bank_full_d[drain_bank_q] = 1'b0;
            drain_bank_d              = ~drain_bank_q;
        end
        if (accept && (wr_ptr_q == PTR_MAX)) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_bank_d  = rd_bank_q;
        rd_ptr_d   = rd_ptr_q;
        ram_rden_b = 1'b0;

        case (state_q)
            RD_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d    = RD_READ;
                    ram_rden_b = credit;
                end
            end
            RD_READ: begin
                ram_rden_b = credit;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase

        if (ram_rden_b) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (rd_ptr_q == PTR_MAX) begin
                rd_bank_d = ~rd_bank_q;
                state_d   = RD_IDLE;
            end
        end

        inflight_d      = ram_rden_b;
        inflight_last_d = ram_rden_b & (rd_ptr_q == PTR_MAX);
    end

    always_comb begin
        fifo_data_d   = fifo_data_q;
        fifo_last_d   = fifo_last_q;
        fifo_wr_idx_d = fifo_wr_idx_q;
        fifo_rd_idx_d = fifo_rd_idx_q;
        fifo_cnt_d    = fifo_cnt_q;

        if (push) begin
            fifo_data_d[fifo_wr_idx_q] = ram_dout_b;
            fifo_last_d[fifo_wr_idx_q] = inflight_last_q;
            fifo_wr_idx_d              = ~fifo_wr_idx_q;
        end
        if (pop) begin
            fifo_rd_idx_d = ~fifo_rd_idx_q;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= RD_IDLE;
            wr_bank_q       <= 1'b0;
            wr_ptr_q        <= '0;
            rd_bank_q       <= 1'b0;
            rd_ptr_q        <= '0;
            drain_bank_q    <= 1'b0;
            bank_full_q     <= 2'b00;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q     <= 2'b00;
            fifo_wr_idx_q   <= 1'b0;
            fifo_rd_idx_q   <= 1'b0;
            fifo_cnt_q      <= 2'd0;
        end else begin
            state_q         <= state_d;
            wr_bank_q       <= wr_bank_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_bank_q       <= rd_bank_d;
            rd_ptr_q        <= rd_ptr_d;
            drain_bank_q    <= drain_bank_d;
            bank_full_q     <= bank_full_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            fifo_wr_idx_q   <= fifo_wr_idx_d;
            fifo_rd_idx_q   <= fifo_rd_idx_d;
            fifo_cnt_q      <= fifo_cnt_d;
        end
    end

endmodule

// File: tb/tb_pingpong_ram_ctrl.sv
module tb_pingpong_ram_ctrl;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int FL = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          ram_wren_a;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_din_a;
    logic          ram_rden_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_dout_b = '0;
    logic [1:0]    bank_full;
    logic          frame_done;

    pingpong_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .ram_wren_a(ram_wren_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
        .ram_rden_b(ram_rden_b), .ram_addr_b(ram_addr_b), .ram_dout_b(ram_dout_b),
        .bank_full(bank_full), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM, one clock read latency on port B.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (ram_wren_a) mem[ram_addr_a] <= ram_din_a;
        if (ram_rden_b) ram_dout_b <= mem[ram_addr_b];
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rdy_mode = 0;   // 0: m_ready low, 1: high, 2: random

    always @(posedge clk) begin
        cyc++;
        #1;
        case (rdy_mode)
            1:       m_ready = 1'b1;
            2:       m_ready = 1'($urandom % 2);
            default: m_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle.
    logic [DW-1:0] exp_q [$];
    int wr_count = 0, rd_count = 0, out_count = 0, fd_count = 0;
    int acc_frame_cyc = 0, mv_rise_cyc = 0, gaps = 0;
    int overlap_ok = 0, overlap_bad = 0;
    bit prev_stall = 0, mv_prev = 0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            wr_count = 0; rd_count = 0; out_count = 0;
            prev_stall = 0; mv_prev = 0;
        end else begin
            chk("outstanding_le2", 32'(rd_count - out_count <= 2), 1);
            chk("wren_a", ram_wren_a, s_valid && s_ready);
            if (s_valid && s_ready) begin
                chk("addr_a", ram_addr_a, wr_count % 32);
                chk("din_a", ram_din_a, s_data);
                exp_q.push_back(s_data);
                wr_count++;
                if (wr_count % FL == 0) acc_frame_cyc = cyc;
            end
            if (ram_rden_b) begin
                chk("addr_b", ram_addr_b, rd_count % 32);
                rd_count++;
            end
            if (ram_wren_a && ram_rden_b) begin
                if (ram_addr_a[AW-1] != ram_addr_b[AW-1]) overlap_ok++;
                else overlap_bad++;
            end
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
            end
            if (m_valid && !mv_prev) mv_rise_cyc = cyc;
            if (!m_valid && (out_count % FL != 0)) gaps++;
            if (frame_done) fd_count++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    chk("m_data", m_data, exp_q.pop_front());
                end
                chk("m_last", m_last, 32'(out_count % FL == FL - 1));
                chk("frame_done", frame_done, 32'(out_count % FL == FL - 1));
                out_count++;
            end else begin
                chk("frame_done_idle", frame_done, 0);
            end
            mv_prev    = m_valid;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic send(input int n, input int base);
        int waitc;
        bit done;
        for (int i = 0; i < n; i++) begin
            waitc = 0;
            done = 0;
            s_valid = 1'b1;
            s_data = DW'(base + i);
            while (!done) begin
                @(negedge clk);
                if (s_ready) begin
                    done = 1;
                end else begin
                    waitc++;
                    if (waitc > 300) begin
                        chk("send_timeout", 0, 1);
                        done = 1;
                    end
                end
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b0;
        s_data = '0;
    endtask

    task automatic drain();
        int waitc;
        waitc = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && !m_valid && bank_full == 2'b00) && waitc < 400) begin
            waitc++;
            @(negedge clk);
        end
        chk("drain_in_time", 32'(waitc < 400), 1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_wren_a", ram_wren_a, 0);
        chk("rst_rden_b", ram_rden_b, 0);
        chk("rst_addr_a", ram_addr_a, 0);
        chk("rst_addr_b", ram_addr_b, 0);
        chk("rst_bank_full", bank_full, 0);
    endtask

    typedef struct {
        int       nwords;
        int       mode;
        int       exp_frames;
        logic [1:0] exp_full;
        bit       chk_lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int fd0, out0;
        vecs[0] = '{16, 1, 1, 2'b00, 1'b1};
        vecs[1] = '{64, 1, 4, 2'b00, 1'b0};
        vecs[2] = '{48, 2, 3, 2'b00, 1'b0};
        vecs[3] = '{32, 2, 2, 2'b00, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready, 1);

        for (int i = 0; i < 4; i++) begin
            fd0 = fd_count;
            out0 = out_count;
            gaps = 0;
            rdy_mode = vecs[i].mode;
            @(posedge clk); #1;
            send(vecs[i].nwords, 0);
            drain();
            chk("vec_frames", fd_count - fd0, vecs[i].exp_frames);
            chk("vec_words_out", out_count - out0, vecs[i].nwords);
            chk("vec_bank_full", bank_full, vecs[i].exp_full);
            chk("vec_mid_frame_gaps", gaps, 0);
            if (vecs[i].chk_lat) chk("first_out_latency", mv_rise_cyc - acc_frame_cyc, 3);
        end

        // Both banks fill while the output is stalled, then release.
        fd0 = fd_count;
        rdy_mode = 0;
        @(posedge clk); #1;
        send(32, 0);
        @(negedge clk);
        chk("both_full_s_ready", s_ready, 0);
        chk("both_full_bank_full", bank_full, 2'b11);
        repeat (3) @(negedge clk);
        chk("stalled_m_valid", m_valid, 1);
        chk("stalled_still_full", bank_full, 2'b11);
        rdy_mode = 1;
        send(16, 32);
        drain();
        chk("stall_frames", fd_count - fd0, 3);

        // Writer and reader active together on opposite banks.
        overlap_ok = 0;
        overlap_bad = 0;
        rdy_mode = 1;
        @(posedge clk); #1;
        send(32, 64);
        drain();
        chk("overlap_seen", 32'(overlap_ok > 0), 1);
        chk("overlap_same_bank", overlap_bad, 0);

        // Reset in the middle of a burst discards everything.
        rdy_mode = 0;
        @(posedge clk); #1;
        send(21, 100);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        fd0 = fd_count;
        rdy_mode = 1;
        send(16, 0);
        drain();
        chk("after_reset_frames", fd_count - fd0, 1);
        chk("after_reset_words", out_count, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
